// File: rtl/imm_enc.sv
// -----------------------------------------------------------------------------
// imm_enc -- RV32 immediate encoder (inverse of the immediate extender)
//
// Takes a 32-bit two's-complement immediate, an immediate format and a base
// instruction word. It scatters the immediate bits into the instruction fields
// of that format and flags immediates that the format cannot represent. It is
// used in the self-test / instruction-generator path that writes instruction
// memory.
//
// Structure: two-stage valid/ready pipeline.
//   S1 holds the accepted input beat.
//   S2 holds the encoded word and its error flag.
// Latency is two cycles from the input handshake to valid_o. The pipeline
// sustains one beat per cycle while ready_i is high.
//
// Optional feature (macro ROUNDTRIP_CHECK_EN):
//   defined   : S2 re-extracts the immediate from the encoded word and
//               compares it with the registered immediate on every error-free
//               valid beat. A mismatch sets the sticky rt_fail_o.
//   undefined : no decode logic is built and rt_fail_o is tied to 0.
//
// Parameters:
//   CNT_W      width of the saturating error counter err_cnt_o
//
// Ports:
//   clk_i      clock, rising edge
//   rst_ni     synchronous active-low reset
//   valid_i    input beat valid
//   ready_o    block can accept an input beat (combinational from ready_i)
//   imm_i      immediate value
//   imm_src_i  format: 000 I, 001 S, 010 B, 011 U, 100 J, others illegal
//   base_i     instruction word supplying every non-immediate bit
//   valid_o    output beat valid
//   ready_i    downstream accepts the output beat
//   instr_o    encoded instruction
//   err_o      immediate not representable or illegal format; qualified by
//              valid_o
//   err_cnt_o  number of errored output handshakes; saturates at all-ones
//   rt_fail_o  sticky round-trip mismatch flag
// -----------------------------------------------------------------------------
module imm_enc #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [31:0]      imm_i,
  input  logic [2:0]       imm_src_i,
  input  logic [31:0]      base_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [31:0]      instr_o,
  output logic             err_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic             rt_fail_o
);

  localparam logic [2:0] FMT_I = 3'b000;
  localparam logic [2:0] FMT_S = 3'b001;
  localparam logic [2:0] FMT_B = 3'b010;
  localparam logic [2:0] FMT_U = 3'b011;
  localparam logic [2:0] FMT_J = 3'b100;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Scatter the immediate into the format's fields. Every other bit is kept
  // from base. Out-of-range immediates are still placed, truncated to the
  // field width. Illegal formats return base unchanged.
  function automatic logic [31:0] place_imm(input logic [31:0] imm,
                                            input logic [2:0]  fmt,
                                            input logic [31:0] base);
    logic [31:0] w;
    w = base;
    case (fmt)
      FMT_I: w[31:20] = imm[11:0];
      FMT_S: begin
        w[31:25] = imm[11:5];
        w[11:7]  = imm[4:0];
      end
      FMT_B: begin
        w[31]    = imm[12];
        w[7]     = imm[11];
        w[30:25] = imm[10:5];
        w[11:8]  = imm[4:1];
      end
      FMT_U: w[31:12] = imm[31:12];
      FMT_J: begin
        w[31]    = imm[20];
        w[30:21] = imm[10:1];
        w[20]    = imm[11];
        w[19:12] = imm[19:12];
      end
      default: w = base;
    endcase
    return w;
  endfunction

  // The value is representable when every bit above the field's sign bit
  // equals that sign bit. Branch and jump offsets must also be even.
  function automatic logic range_err(input logic [31:0] imm,
                                     input logic [2:0]  fmt);
    logic e;
    case (fmt)
      FMT_I, FMT_S: e = ~((&imm[31:11]) | ~(|imm[31:11]));
      FMT_B:        e = ~(((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0]);
      FMT_J:        e = ~(((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0]);
      FMT_U:        e = |imm[11:0];
      default:      e = 1'b1;
    endcase
    return e;
  endfunction

  // ---------------------------------------------------------------------------
  // Pipeline state
  // ---------------------------------------------------------------------------
  logic        s1_valid_r;
  logic [31:0] s1_imm_r;
  logic [2:0]  s1_src_r;
  logic [31:0] s1_base_r;

  logic        s2_valid_r;
  logic [31:0] s2_instr_r;
  logic        s2_err_r;

  logic [CNT_W-1:0] err_cnt_r;

  logic        s1_adv_s;
  logic        s2_load_s;
  logic        in_hs_s;
  logic [31:0] enc_word_s;
  logic        enc_err_s;
  logic        cnt_inc_s;

  // Handshake and advance control. ready_o looks through S1 to ready_i, so a
  // full pipeline keeps streaming when the downstream drains.
  always_comb begin
    s2_load_s = ~s2_valid_r | ready_i;
    s1_adv_s  = s1_valid_r & s2_load_s;
    ready_o   = ~s1_valid_r | s1_adv_s;
    in_hs_s   = valid_i & ready_o;
    cnt_inc_s = s2_valid_r & ready_i & s2_err_r & ~(&err_cnt_r);
  end

  // Encode the beat held in S1.
  always_comb begin
    enc_word_s = place_imm(s1_imm_r, s1_src_r, s1_base_r);
    enc_err_s  = range_err(s1_imm_r, s1_src_r);
  end

  // S1 register: captures the input beat on a handshake. It empties when its
  // beat moves on and no new beat arrives.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_valid_r <= 1'b0;
      s1_imm_r   <= 32'h0000_0000;
      s1_src_r   <= 3'b000;
      s1_base_r  <= 32'h0000_0000;
    end else begin
      if (ready_o) begin
        s1_valid_r <= valid_i;
      end
      if (in_hs_s) begin
        s1_imm_r  <= imm_i;
        s1_src_r  <= imm_src_i;
        s1_base_r <= base_i;
      end
    end
  end

  // S2 register: captures the encoded result. It holds while the downstream
  // stalls, so instr_o and err_o stay stable.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s2_valid_r <= 1'b0;
      s2_instr_r <= 32'h0000_0000;
      s2_err_r   <= 1'b0;
    end else if (s2_load_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_instr_r <= enc_word_s;
        s2_err_r   <= enc_err_s;
      end
    end
  end

  // Saturating count of errored output handshakes.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_inc_s) begin
      err_cnt_r <= err_cnt_r + CNT_ONE;
    end
  end

  assign valid_o   = s2_valid_r;
  assign instr_o   = s2_instr_r;
  assign err_o     = s2_err_r;
  assign err_cnt_o = err_cnt_r;

`ifdef ROUNDTRIP_CHECK_EN
  // Sign-extending extraction, matching the immediate extender.
  function automatic logic [31:0] extract_imm(input logic [31:0] w,
                                              input logic [2:0]  fmt);
    logic [31:0] v;
    case (fmt)
      FMT_I:   v = {{20{w[31]}}, w[31:20]};
      FMT_S:   v = {{20{w[31]}}, w[31:25], w[11:7]};
      FMT_B:   v = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      FMT_U:   v = {w[31:12], 12'h000};
      FMT_J:   v = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: v = 32'h0000_0000;
    endcase
    return v;
  endfunction

  logic [31:0] s2_imm_r;
  logic [2:0]  s2_src_r;
  logic        rt_fail_r;
  logic        rt_mis_s;

  // Keep the original immediate and format alongside the S2 word.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s2_imm_r <= 32'h0000_0000;
      s2_src_r <= 3'b000;
    end else if (s2_load_s & s1_valid_r) begin
      s2_imm_r <= s1_imm_r;
      s2_src_r <= s1_src_r;
    end
  end

  // Errored beats are excluded: their fields are truncated by design.
  always_comb begin
    rt_mis_s = s2_valid_r & ~s2_err_r &
               (extract_imm(s2_instr_r, s2_src_r) != s2_imm_r);
  end

  // Sticky round-trip failure flag; only reset clears it.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rt_fail_r <= 1'b0;
    end else if (rt_mis_s) begin
      rt_fail_r <= 1'b1;
    end
  end

  assign rt_fail_o = rt_fail_r;
`else
  assign rt_fail_o = 1'b0;
`endif

endmodule

// File: tb/tb_imm_enc.sv
module tb_imm_enc;

  localparam logic [2:0] FMT_I = 3'b000;
  localparam logic [2:0] FMT_S = 3'b001;
  localparam logic [2:0] FMT_B = 3'b010;
  localparam logic [2:0] FMT_U = 3'b011;
  localparam logic [2:0] FMT_J = 3'b100;
  localparam logic [2:0] FMT_X = 3'b111;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [31:0] imm_i = 32'h0;
  logic [2:0]  imm_src_i = 3'b000;
  logic [31:0] base_i = 32'h0;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic [31:0] instr_o;
  logic        err_o;
  logic [15:0] err_cnt_o;
  logic        rt_fail_o;

  // Second instance with a tiny counter to reach saturation quickly.
  logic        sat_valid_i = 1'b0;
  logic        sat_ready_o;
  logic        sat_valid_o;
  logic [31:0] sat_instr_o;
  logic        sat_err_o;
  logic [2:0]  sat_cnt_o;
  logic        sat_rt_fail_o;

  int checks = 0;
  int failures = 0;
  int exp_cnt = 0;

  always #5 clk_i = ~clk_i;

  imm_enc #(.CNT_W(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
    .imm_i(imm_i), .imm_src_i(imm_src_i), .base_i(base_i),
    .valid_o(valid_o), .ready_i(ready_i), .instr_o(instr_o), .err_o(err_o),
    .err_cnt_o(err_cnt_o), .rt_fail_o(rt_fail_o)
  );

  imm_enc #(.CNT_W(3)) dut_sat (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(sat_valid_i), .ready_o(sat_ready_o),
    .imm_i(32'h0000_0001), .imm_src_i(FMT_X), .base_i(32'h0000_0013),
    .valid_o(sat_valid_o), .ready_i(1'b1), .instr_o(sat_instr_o), .err_o(sat_err_o),
    .err_cnt_o(sat_cnt_o), .rt_fail_o(sat_rt_fail_o)
  );

  // Reference extraction written from the RV32 field layout.
  function automatic logic [31:0] ref_extract(input logic [31:0] w, input logic [2:0] fmt);
    case (fmt)
      FMT_I:   return {{20{w[31]}}, w[31:20]};
      FMT_S:   return {{20{w[31]}}, w[31:25], w[11:7]};
      FMT_B:   return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      FMT_U:   return {w[31:12], 12'h000};
      default: return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    endcase
  endfunction

  function automatic logic [31:0] imm_mask(input logic [2:0] fmt);
    case (fmt)
      FMT_I:        return 32'hFFF0_0000;
      FMT_S, FMT_B: return 32'hFE00_0F80;
      default:      return 32'hFFFF_F000;
    endcase
  endfunction

  // Send one beat with ready_i=1 and wait (bounded) for it at the output.
  task automatic run_beat(input logic [31:0] imm, input logic [2:0] src,
                          input logic [31:0] base, output logic [31:0] instr,
                          output logic err, output int lat);
    @(negedge clk_i);
    ready_i = 1'b1; valid_i = 1'b1; imm_i = imm; imm_src_i = src; base_i = base;
    @(posedge clk_i);
    #1 valid_i = 1'b0;
    lat = -1; instr = 32'h0; err = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk_i);
      if (valid_o === 1'b1) begin
        lat = k; instr = instr_o; err = err_o;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    checks++;
    if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    checks++;
    if (instr_o !== 32'h0) begin failures++; $display("FAIL reset_instr: got %h want 00000000", instr_o); end
    checks++;
    if (err_o !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", err_o); end
    checks++;
    if (err_cnt_o !== 16'h0) begin failures++; $display("FAIL reset_cnt: got %h want 0000", err_cnt_o); end
    checks++;
    if (rt_fail_o !== 1'b0) begin failures++; $display("FAIL reset_rt: got %b want 0", rt_fail_o); end
    checks++;
    if (ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", ready_o); end
    rst_ni = 1'b1;
  endtask

  task automatic test_encode();
    logic [31:0] imms[4]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0000_0800, 32'h1234_5000};
    logic [2:0]  srcs[4]  = '{FMT_I, FMT_S, FMT_B, FMT_U};
    logic [31:0] bases[4] = '{32'h0000_0013, 32'h0011_2023, 32'h0000_0063, 32'h0000_0537};
    logic [31:0] exps[4]  = '{32'hFFF0_0013, 32'hFE11_2E23, 32'h0000_00E3, 32'h1234_5537};
    logic [31:0] instr; logic err; int lat;
    for (int i = 0; i < 4; i++) begin
      run_beat(imms[i], srcs[i], bases[i], instr, err, lat);
      checks++;
      if (lat != 2) begin failures++; $display("FAIL enc_latency[%0d]: got %0d want 2", i, lat); end
      checks++;
      if (instr !== exps[i] || err !== 1'b0) begin
        failures++;
        $display("FAIL enc_word[%0d]: got %h err=%b want %h err=0", i, instr, err, exps[i]);
      end
    end
    @(negedge clk_i);
    checks++;
    if (err_cnt_o !== 16'(exp_cnt)) begin failures++; $display("FAIL enc_cnt: got %0d want %0d", err_cnt_o, exp_cnt); end
  endtask

  task automatic test_errors();
    logic [31:0] imms[4]  = '{32'h1234_5001, 32'h0000_0800, 32'h0000_0003, 32'h0000_0004};
    logic [2:0]  srcs[4]  = '{FMT_U, FMT_I, FMT_J, FMT_X};
    logic [31:0] bases[4] = '{32'h0000_0537, 32'h0000_0013, 32'h0000_006F, 32'hDEAD_BEEF};
    logic [31:0] exps[4]  = '{32'h1234_5537, 32'h8000_0013, 32'h0020_006F, 32'hDEAD_BEEF};
    logic [31:0] instr; logic err; int lat;
    for (int i = 0; i < 4; i++) begin
      run_beat(imms[i], srcs[i], bases[i], instr, err, lat);
      checks++;
      if (lat != 2 || instr !== exps[i] || err !== 1'b1) begin
        failures++;
        $display("FAIL err_beat[%0d]: got lat=%0d %h err=%b want lat=2 %h err=1", i, lat, instr, err, exps[i]);
      end
      exp_cnt++;
      @(negedge clk_i);
      checks++;
      if (err_cnt_o !== 16'(exp_cnt)) begin failures++; $display("FAIL err_cnt[%0d]: got %0d want %0d", i, err_cnt_o, exp_cnt); end
    end
  endtask

  task automatic test_back_to_back();
    int sent = 0, got = 0;
    logic dropped = 1'b0, prev_stall = 1'b0, hs_in, hs_out;
    logic [31:0] prev_instr = 32'h0, exp_w;
    for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
      @(negedge clk_i);
      if (prev_stall) begin
        checks++;
        if (valid_o !== 1'b1 || instr_o !== prev_instr || err_o !== 1'b0) begin
          failures++;
          $display("FAIL stall_hold: got valid=%b %h want valid=1 %h", valid_o, instr_o, prev_instr);
        end
      end
      ready_i = !(cyc >= 2 && cyc <= 4);
      valid_i = (sent < 4);
      imm_i = 32'(sent + 1); imm_src_i = FMT_I; base_i = 32'h0000_0013;
      #1;
      if (ready_o === 1'b0) dropped = 1'b1;
      hs_in  = valid_i & ready_o;
      hs_out = valid_o & ready_i;
      if (hs_out) begin
        exp_w = (32'(got + 1) << 20) | 32'h0000_0013;
        checks++;
        if (instr_o !== exp_w || err_o !== 1'b0) begin
          failures++;
          $display("FAIL b2b_order[%0d]: got %h err=%b want %h err=0", got, instr_o, err_o, exp_w);
        end
        got++;
      end
      prev_stall = valid_o & !ready_i;
      prev_instr = instr_o;
      if (hs_in) sent++;
    end
    @(negedge clk_i);
    valid_i = 1'b0; ready_i = 1'b1;
    checks++;
    if (got != 4) begin failures++; $display("FAIL b2b_count: got %0d want 4", got); end
    checks++;
    if (dropped !== 1'b1) begin failures++; $display("FAIL b2b_ready_drop: got %b want 1", dropped); end
    repeat (3) @(negedge clk_i);
    checks++;
    if (valid_o !== 1'b0) begin failures++; $display("FAIL b2b_no_dup: got valid=%b want 0", valid_o); end
  endtask

  task automatic test_random_legal();
    logic [31:0] r, imm, base, instr, m; logic [2:0] fmt; logic err; int lat;
    int bad = 0;
    for (int n = 0; n < 200; n++) begin
      r = $urandom; base = $urandom; fmt = 3'($urandom_range(0, 4));
      case (fmt)
        FMT_I, FMT_S: imm = {{21{r[11]}}, r[10:0]};
        FMT_B:        imm = {{20{r[12]}}, r[11:1], 1'b0};
        FMT_U:        imm = {r[31:12], 12'h000};
        default:      imm = {{12{r[20]}}, r[19:1], 1'b0};
      endcase
      run_beat(imm, fmt, base, instr, err, lat);
      m = imm_mask(fmt);
      checks++;
      if (lat != 2 || err !== 1'b0 || ref_extract(instr, fmt) !== imm || (instr & ~m) !== (base & ~m)) begin
        failures++;
        if (bad < 5) $display("FAIL rand[%0d]: fmt=%0d imm=%h base=%h got %h err=%b lat=%0d", n, fmt, imm, base, instr, err, lat);
        bad++;
      end
    end
    @(negedge clk_i);
    checks++;
    if (rt_fail_o !== 1'b0) begin failures++; $display("FAIL rt_fail: got %b want 0", rt_fail_o); end
    checks++;
    if (err_cnt_o !== 16'(exp_cnt)) begin failures++; $display("FAIL rand_cnt: got %0d want %0d", err_cnt_o, exp_cnt); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk_i);
    ready_i = 1'b1; valid_i = 1'b1; imm_i = 32'h0; imm_src_i = FMT_X; base_i = 32'h0000_0013;
    @(negedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b0; rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    checks++;
    if (valid_o !== 1'b0) begin failures++; $display("FAIL midrst_valid: got %b want 0", valid_o); end
    checks++;
    if (err_cnt_o !== 16'h0) begin failures++; $display("FAIL midrst_cnt: got %0d want 0", err_cnt_o); end
    exp_cnt = 0;
    repeat (3) @(negedge clk_i);
    checks++;
    if (valid_o !== 1'b0 || err_cnt_o !== 16'h0) begin
      failures++;
      $display("FAIL midrst_discard: got valid=%b cnt=%0d want valid=0 cnt=0", valid_o, err_cnt_o);
    end
  endtask

  task automatic test_saturation();
    @(negedge clk_i);
    sat_valid_i = 1'b1;
    repeat (5) @(negedge clk_i);
    sat_valid_i = 1'b0;
    repeat (4) @(negedge clk_i);
    checks++;
    if (sat_cnt_o !== 3'd5) begin failures++; $display("FAIL sat_count5: got %0d want 5", sat_cnt_o); end
    sat_valid_i = 1'b1;
    repeat (5) @(negedge clk_i);
    sat_valid_i = 1'b0;
    repeat (4) @(negedge clk_i);
    checks++;
    if (sat_cnt_o !== 3'd7) begin failures++; $display("FAIL sat_hold: got %0d want 7", sat_cnt_o); end
  endtask

  initial begin
    test_reset();
    test_encode();
    test_errors();
    test_back_to_back();
    test_random_legal();
    test_reset_mid();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imm_enc.md
Name: imm_enc

Overview:
Inverse of the immediate extender. Takes a 32-bit immediate, an immediate format and a base instruction word. Places the immediate bits into the RV32 instruction fields for that format and range-checks that the immediate is representable. Sits in the self-test / instruction-generator path that writes instruction memory; a 2-stage valid/ready pipeline with a saturating error counter.

Parameters:
CNT_W, 16, width of saturating error counter err_cnt_o

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  reset, synchronous, active-low
valid_i  input  1  input beat valid
ready_o  output  1  block can accept input beat
imm_i  input  32  immediate value (two's complement)
imm_src_i  input  3  format: 000 I, 001 S, 010 B, 011 U, 100 J
base_i  input  32  instruction word supplying all non-immediate bits
valid_o  output  1  output beat valid
ready_i  input  1  downstream accepts output beat
instr_o  output  32  encoded instruction
err_o  output  1  immediate not representable / illegal format, qualified by valid_o
err_cnt_o  output  CNT_W  count of errored output handshakes, saturating
rt_fail_o  output  1  sticky round-trip mismatch (see Optional Feature)

Behaviour:
- Clock is one domain, clk_i. Reset is synchronous and active-low (rst_ni sampled on clk_i rising edge).
- Reset values: valid_o=0, instr_o=0, err_o=0, err_cnt_o=0, rt_fail_o=0, both stage valids 0.
- Pipeline: S1 registers inputs on an input handshake (valid_i & ready_o). S2 registers the encoded result and error. Latency is 2 cycles from input handshake to valid_o. Full throughput, 1 beat/cycle, when ready_i=1.
- Advance rules:
  - S1 advances to S2 when S2 is empty or ready_i=1.
  - ready_o = !s1_valid | s1_advance. This is combinational from ready_i.
- Stall: while valid_o=1 & ready_i=0, instr_o and err_o hold stable. No beat is dropped or duplicated.
- Encoding, with all other bits taken from base_i:
  - I: [31:20]=imm[11:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[12], [7]=imm[11], [30:25]=imm[10:5], [11:8]=imm[4:1].
  - U: [31:12]=imm[31:12].
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
- Range check; err=1 when the condition fails:
  - I/S: imm[31:11] all equal.
  - B: imm[31:12] all equal and imm[0]=0.
  - J: imm[31:20] all equal and imm[0]=0.
  - U: imm[11:0]=0.
  - imm_src_i 101..111: instr=base_i unchanged, err=1.
- On error, instr_o still carries the truncated field placement. err_o flags it.
- err_cnt_o increments by 1 on each output handshake (valid_o & ready_i) with err_o=1. It saturates at all-ones.
- Reset asserted mid-operation: all in-flight beats are discarded, and counter and sticky flag return to 0 on the next edge.

Optional Feature:
Macro ROUNDTRIP_CHECK_EN.
- Defined: S2 re-decodes the encoded word using the same sign-extending extraction as the extender. On each valid beat with err=0 it compares the result against the registered imm. Any mismatch sets rt_fail_o, which stays set until reset.
- Not defined: no decode logic; rt_fail_o tied to 0.

Test Plan:
- I-type: imm=0xFFFFFFFF, base=0x00000013, ready_i=1 -> 2 cycles later valid_o=1, instr_o=0xFFF00013, err_o=0.
- S-type: imm=0xFFFFFFFC, base=0x00112023 -> instr_o=0xFE112E23, err_o=0. B-type: imm=0x00000800, base=0x00000063 -> instr_o=0x000000E3, err_o=0.
- U-type: imm=0x12345000, base=0x00000537 -> instr_o=0x12345537, err=0. U-type: imm=0x12345001 -> err_o=1, err_cnt_o increments to 1 after the handshake.
- Errors:
  - I-type imm=0x00000800, base=0x00000013 -> instr_o=0x80000013, err_o=1.
  - J-type imm=0x00000003 -> err_o=1.
  - imm_src_i=111 -> instr_o=base_i, err_o=1.
- Backpressure: stream 4 beats and hold ready_i=0 for 3 cycles -> ready_o drops once S1 and S2 are full; outputs stay stable; all 4 beats emerge in order with no loss or duplication. Drive rst_ni=0 for one cycle mid-stream -> valid_o=0 and err_cnt_o=0 next cycle.
- With ROUNDTRIP_CHECK_EN: 1000 random legal (imm, format) pairs -> rt_fail_o stays 0. Force 0x7FF into the counter's saturation path -> err_cnt_o stops at 0xFFFF.
